// File: rtl/plru_tree_ctrl_pkg.sv
// Shared definitions for the tree pseudo-LRU controller: clear-sweep state
// encoding and heap-index helpers used to locate the nodes on a way's path.
package plru_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Heap node visited at level lvl (root = level 0 = node 1) on the way to leaf 'way'.
  function automatic int unsigned path_node(int unsigned way, int unsigned lvl,
                                            int unsigned wid);
    return (32'd1 << lvl) | (way >> (wid - lvl));
  endfunction

  // Direction taken at level lvl towards 'way' (0 = left/lower, 1 = right/upper).
  function automatic logic way_bit(int unsigned way, int unsigned lvl, int unsigned wid);
    return ((way >> (wid - 1 - lvl)) & 32'd1) != 32'd0;
  endfunction

endpackage

// File: rtl/plru_tree_ctrl_logic.sv
// Combinational tree PLRU datapath: applies an optional touch/demote to one
// set's tree bits and walks the resulting tree to the victim way.
module plru_tree_logic
  import plru_pkg::*;
#(
  parameter int ASSOC     = 4,
  parameter int ASSOC_WID = $clog2(ASSOC)
) (
  input  logic [ASSOC-2:0]     tree_i,
  input  logic                 upd_en_i,
  input  logic [ASSOC_WID-1:0] way_i,
  input  logic                 demote_i,
  output logic [ASSOC-2:0]     tree_o,
  output logic [ASSOC_WID-1:0] victim_o
);

  // Rewrite every node on the path: touch points away from the way, demote towards it.
  always_comb begin
    tree_o = tree_i;
    if (upd_en_i) begin
      for (int l = 0; l < ASSOC_WID; l++) begin
        for (int n = 1; n < ASSOC; n++) begin
          if (n == int'(path_node(32'(way_i), l, ASSOC_WID))) begin
            tree_o[n-1] = demote_i ? way_bit(32'(way_i), l, ASSOC_WID)
                                   : ~way_bit(32'(way_i), l, ASSOC_WID);
          end
        end
      end
    end
  end

  // Walk from the root following the (possibly updated) bits; path bits form the way MSB-first.
  always_comb begin
    int   node;
    logic b;
    node     = 1;
    victim_o = '0;
    for (int l = 0; l < ASSOC_WID; l++) begin
      b = 1'b0;
      for (int n = 1; n < ASSOC; n++) begin
        if (n == node) b = tree_o[n-1];
      end
      victim_o = (victim_o << 1) | ASSOC_WID'(b);
      node     = 2 * node + (b ? 1 : 0);
    end
  end

endmodule

// File: rtl/plru_tree_ctrl.sv
// Tree pseudo-LRU replacement controller: per-set tree storage, registered
// victim lookup with invalid-way preference and update forwarding, and a
// whole-array clear sweep.
// Handshake: lkp_valid sampled at edge N yields victim_valid=1 for exactly the
// following cycle; upd_valid is a fire-and-forget write, dropped while clear_busy.
module plru_tree_ctrl
  import plru_pkg::*;
#(
  parameter int ASSOC       = 4,
  parameter int ASSOC_WID   = $clog2(ASSOC),
  parameter int NUM_OF_SETS = 256,
  parameter int INDEX_WID   = $clog2(NUM_OF_SETS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lkp_valid,
  input  logic [INDEX_WID-1:0] lkp_index,
  input  logic [ASSOC-1:0]     lkp_line_valid,
  output logic                 victim_valid,
  output logic [ASSOC_WID-1:0] victim_way,
  output logic                 victim_from_invalid,
  input  logic                 upd_valid,
  input  logic [INDEX_WID-1:0] upd_index,
  input  logic [ASSOC_WID-1:0] upd_way,
  input  logic                 upd_demote,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output sweep_state_e         dbg_state_o
);

  logic [ASSOC-2:0]     tree_q [NUM_OF_SETS];
  sweep_state_e         state_q, state_d;
  logic [INDEX_WID-1:0] cnt_q, cnt_d;
  logic                 victim_valid_q, victim_from_invalid_q;
  logic [ASSOC_WID-1:0] victim_way_q;

  logic                 upd_in_range, lkp_in_range, upd_ok, fwd;
  logic [ASSOC-2:0]     upd_rd, lkp_rd, upd_tree, unused_lkp_tree;
  logic [ASSOC_WID-1:0] walk_way, unused_upd_walk, way_d;
  logic                 from_inv_d;

  // Range-guarded reads; indices past the last set only happen for non-power-of-two depths.
  always_comb begin
    upd_in_range = 32'(upd_index) < 32'(NUM_OF_SETS);
    lkp_in_range = 32'(lkp_index) < 32'(NUM_OF_SETS);
    upd_rd       = upd_in_range ? tree_q[upd_index] : '0;
    lkp_rd       = lkp_in_range ? tree_q[lkp_index] : '0;
    upd_ok       = upd_valid && upd_in_range && (state_q == IDLE);
    fwd          = upd_ok && lkp_valid && (lkp_index == upd_index);
  end

  plru_tree_logic #(.ASSOC(ASSOC), .ASSOC_WID(ASSOC_WID)) u_upd (
    .tree_i   (upd_rd),
    .upd_en_i (upd_ok),
    .way_i    (upd_way),
    .demote_i (upd_demote),
    .tree_o   (upd_tree),
    .victim_o (unused_upd_walk)
  );

  // The lookup copy replays the same-cycle update so the victim sees post-update bits.
  plru_tree_logic #(.ASSOC(ASSOC), .ASSOC_WID(ASSOC_WID)) u_lkp (
    .tree_i   (lkp_rd),
    .upd_en_i (fwd),
    .way_i    (upd_way),
    .demote_i (upd_demote),
    .tree_o   (unused_lkp_tree),
    .victim_o (walk_way)
  );

  // Victim select: out-of-range forces way 0, any invalid way wins over the tree.
  always_comb begin
    way_d      = walk_way;
    from_inv_d = 1'b0;
    if (!lkp_in_range) begin
      way_d = '0;
    end else if (lkp_line_valid != '1) begin
      from_inv_d = 1'b1;
      way_d      = '0;
      for (int w = ASSOC - 1; w >= 0; w--) begin
        if (!lkp_line_valid[w]) way_d = ASSOC_WID'(w);
      end
    end
  end

  // Clear FSM next state: one set per cycle, last set returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == INDEX_WID'(NUM_OF_SETS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Tree storage: sweep clears have priority; updates are only accepted while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_OF_SETS; s++) tree_q[s] <= '0;
    end else if (state_q == SWEEP) begin
      tree_q[cnt_q] <= '0;
    end else if (upd_ok) begin
      tree_q[upd_index] <= upd_tree;
    end
  end

  // FSM, sweep counter and registered victim response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      victim_valid_q        <= 1'b0;
      victim_way_q          <= '0;
      victim_from_invalid_q <= 1'b0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      victim_valid_q        <= lkp_valid;
      victim_way_q          <= lkp_valid ? way_d : '0;
      victim_from_invalid_q <= lkp_valid && from_inv_d;
    end
  end

  assign victim_valid        = victim_valid_q;
  assign victim_way          = victim_way_q;
  assign victim_from_invalid = victim_from_invalid_q;
  assign clear_busy          = (state_q == SWEEP);
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_plru_tree_ctrl.sv
// Bench for plru_tree_ctrl: two instances (4-way x 8 sets, 8-way x 12 sets),
// heap-arithmetic reference model, expected-response queues and monitors.
module tb_plru_tree_ctrl;
  import plru_pkg::*;

  int n_cmp = 0;
  int n_fail = 0;

  // Clock and resets
  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  always #5 clk = ~clk;

  // Instance A: ASSOC=4, NUM_OF_SETS=8
  logic lv_a, uv_a, ud_a, clr_a, vv_a, vf_a, busy_a;
  logic [2:0] li_a, ui_a;
  logic [3:0] lvb_a;
  logic [1:0] uw_a, vw_a;
  sweep_state_e st_a;

  // Instance B: ASSOC=8, NUM_OF_SETS=12 (indices 12..15 out of range)
  logic lv_b, uv_b, ud_b, clr_b, vv_b, vf_b, busy_b;
  logic [3:0] li_b, ui_b;
  logic [7:0] lvb_b;
  logic [2:0] uw_b, vw_b;
  sweep_state_e st_b;

  plru_tree_ctrl #(.ASSOC(4), .NUM_OF_SETS(8)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .lkp_valid(lv_a), .lkp_index(li_a),
    .lkp_line_valid(lvb_a), .victim_valid(vv_a), .victim_way(vw_a),
    .victim_from_invalid(vf_a), .upd_valid(uv_a), .upd_index(ui_a),
    .upd_way(uw_a), .upd_demote(ud_a), .clear_req(clr_a),
    .clear_busy(busy_a), .dbg_state_o(st_a)
  );

  plru_tree_ctrl #(.ASSOC(8), .NUM_OF_SETS(12)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .lkp_valid(lv_b), .lkp_index(li_b),
    .lkp_line_valid(lvb_b), .victim_valid(vv_b), .victim_way(vw_b),
    .victim_from_invalid(vf_b), .upd_valid(uv_b), .upd_index(ui_b),
    .upd_way(uw_b), .upd_demote(ud_b), .clear_req(clr_b),
    .clear_busy(busy_b), .dbg_state_o(st_b)
  );

  // Reference model: heap bits per set, sweep progress per instance
  bit mdl [2][16][16];
  int assoc_p [2] = '{4, 8};
  int nsets_p [2] = '{8, 12};
  bit swp [2];
  int cnt [2];
  logic [3:0] exp_q_a[$];
  logic [3:0] exp_q_b[$];

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Leaf of way w is heap node assoc+w; each ancestor is re-aimed relative to the child we came from.
  function automatic void mdl_update(int d, int s, int w, bit dem);
    int n;
    n = assoc_p[d] + w;
    while (n > 1) begin
      mdl[d][s][n/2] = dem ? bit'(n % 2) : bit'(1 - n % 2);
      n = n / 2;
    end
  endfunction

  // Expected response encoded as 8*from_invalid + way.
  function automatic int mdl_victim(int d, int s, int lvb);
    int n;
    if (s >= nsets_p[d]) return 0;
    if (lvb != (1 << assoc_p[d]) - 1) begin
      for (int w = 0; w < assoc_p[d]; w++)
        if (((lvb >> w) & 1) == 0) return 8 + w;
    end
    n = 1;
    while (n < assoc_p[d]) n = 2 * n + int'(mdl[d][s][n]);
    return n - assoc_p[d];
  endfunction

  function automatic void model_edge(int d, bit lv, int li, int lvb, bit uv, int ui,
                                     int uw, bit ud, bit clr);
    if (uv && ui < nsets_p[d] && !swp[d]) mdl_update(d, ui, uw, ud);
    if (lv) begin
      if (d == 0) exp_q_a.push_back(4'(mdl_victim(d, li, lvb)));
      else        exp_q_b.push_back(4'(mdl_victim(d, li, lvb)));
    end
    if (swp[d]) begin
      for (int n = 0; n < 16; n++) mdl[d][cnt[d]][n] = 1'b0;
      cnt[d]++;
      if (cnt[d] == nsets_p[d]) swp[d] = 1'b0;
    end else if (clr) begin
      swp[d] = 1'b1;
      cnt[d] = 0;
    end
  endfunction

  function automatic void model_reset(int d);
    for (int s = 0; s < 16; s++)
      for (int n = 0; n < 16; n++) mdl[d][s][n] = 1'b0;
    swp[d] = 1'b0;
    cnt[d] = 0;
  endfunction

  task automatic idle_inputs();
    lv_a = 0; li_a = 0; lvb_a = '1; uv_a = 0; ui_a = 0; uw_a = 0; ud_a = 0; clr_a = 0;
    lv_b = 0; li_b = 0; lvb_b = '1; uv_b = 0; ui_b = 0; uw_b = 0; ud_b = 0; clr_b = 0;
  endtask

  // Driver: one clock with the given inputs on instance d, the other idle.
  task automatic step(int d, bit lv, int li, int lvb, bit uv, int ui, int uw, bit ud, bit clr);
    idle_inputs();
    if (d == 0) begin
      lv_a = lv; li_a = 3'(li); lvb_a = 4'(lvb); uv_a = uv; ui_a = 3'(ui);
      uw_a = 2'(uw); ud_a = ud; clr_a = clr;
    end else begin
      lv_b = lv; li_b = 4'(li); lvb_b = 8'(lvb); uv_b = uv; ui_b = 4'(ui);
      uw_b = 3'(uw); ud_b = ud; clr_b = clr;
    end
    @(posedge clk);
    if (rst_n_a) model_edge(0, lv_a, int'(li_a), int'(lvb_a), uv_a, int'(ui_a), int'(uw_a), ud_a, clr_a);
    if (rst_n_b) model_edge(1, lv_b, int'(li_b), int'(lvb_b), uv_b, int'(ui_b), int'(uw_b), ud_b, clr_b);
    @(negedge clk);
    #1;
    check("pending_a", exp_q_a.size(), 0);
    check("pending_b", exp_q_b.size(), 0);
    check("busy_a", int'(busy_a), int'(swp[0]));
    check("busy_b", int'(busy_b), int'(swp[1]));
    check("state_a", int'(st_a), int'(swp[0]));
    idle_inputs();
  endtask

  task automatic lookup(int d, int s, int lvb);
    step(d, 1, s, lvb, 0, 0, 0, 0, 0);
  endtask

  task automatic update(int d, int s, int w, bit dem);
    step(d, 0, 0, 0, 1, s, w, dem, 0);
  endtask

  task automatic idle_cycle(int d);
    step(d, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitors: pop an expectation whenever a response is presented.
  logic [3:0] e_a, e_b;
  always @(negedge clk) begin
    if (vv_a === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL victim_a: response way %0d with no lookup pending at %0t", vw_a, $time);
      end else begin
        e_a = exp_q_a.pop_front();
        check("victim_a", int'({vf_a, 1'b0, vw_a}), int'(e_a));
      end
    end
  end

  always @(negedge clk) begin
    if (vv_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL victim_b: response way %0d with no lookup pending at %0t", vw_b, $time);
      end else begin
        e_b = exp_q_b.pop_front();
        check("victim_b", int'({vf_b, vw_b}), int'(e_b));
      end
    end
  end

  task automatic random_phase(int d, int iters);
    int li, lvb, ui, amask;
    amask = (1 << assoc_p[d]) - 1;
    for (int i = 0; i < iters; i++) begin
      li  = $urandom_range(0, (d == 0) ? 7 : 15);
      lvb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, amask)) : amask;
      ui  = ($urandom_range(0, 9) < 4) ? li : int'($urandom_range(0, (d == 0) ? 7 : 15));
      step(d, bit'($urandom_range(0, 1)), li, lvb, bit'($urandom_range(0, 1)), ui,
           $urandom_range(0, assoc_p[d] - 1), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0));
    end
  endtask

  initial begin
    idle_inputs();
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_vv_a", int'(vv_a), 0);
    check("rst_way_a", int'(vw_a), 0);
    check("rst_flag_a", int'(vf_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_vv_b", int'(vv_b), 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Instance A: fresh lookup, touch sequence, invalid preference
    lookup(0, 5, 4'b1111);
    update(0, 5, 0, 0); lookup(0, 5, 4'b1111);
    update(0, 5, 2, 0); lookup(0, 5, 4'b1111);
    update(0, 5, 1, 0); lookup(0, 5, 4'b1111);
    lookup(0, 6, 4'b1011);
    lookup(0, 5, 4'b0111);
    // Touch then demote, and same-cycle forwarding versus different-set lookup
    update(0, 3, 0, 0); update(0, 3, 0, 1); lookup(0, 3, 4'b1111);
    step(0, 1, 7, 4'b1111, 1, 7, 0, 0, 0);
    step(0, 1, 6, 4'b1111, 1, 7, 3, 0, 0);
    lookup(0, 7, 4'b1111);
    idle_cycle(0);
    check("lookup_idle_vv_a", int'(vv_a), 0);

    // Sweep on A: populate, clear, lose an update mid-sweep, lookups during and after
    for (int s = 0; s < 8; s++) update(0, s, $urandom_range(0, 3), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_cycle(0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    update(0, 7, 0, 0);
    lookup(0, 7, 4'b1111);
    for (int i = 0; i < 5; i++) idle_cycle(0);
    for (int s = 0; s < 8; s++) lookup(0, s, 4'b1111);

    random_phase(0, 300);
    for (int i = 0; i < 10; i++) idle_cycle(0);

    // Instance B: touch all ways in order, out-of-range accesses
    for (int w = 0; w < 8; w++) update(1, 1, w, 0);
    lookup(1, 1, 8'hff);
    update(1, 13, 2, 0);
    lookup(1, 13, 8'h00);
    lookup(1, 2, 8'b1111_0111);
    random_phase(1, 300);
    for (int i = 0; i < 14; i++) idle_cycle(1);

    // Reset in the middle of a sweep on B
    update(1, 4, 5, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_cycle(1); idle_cycle(1);
    lookup(1, 4, 8'hff);
    rst_n_b = 1'b0;
    #1;
    check("midrst_busy_b", int'(busy_b), 0);
    check("midrst_vv_b", int'(vv_b), 0);
    check("midrst_way_b", int'(vw_b), 0);
    check("midrst_flag_b", int'(vf_b), 0);
    check("midrst_state_b", int'(st_b), int'(IDLE));
    model_reset(1);
    exp_q_b.delete();
    #1;
    rst_n_b = 1'b1;
    lookup(1, 4, 8'hff);
    lookup(1, 1, 8'hff);
    random_phase(1, 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
